// File: rtl/boton_encoder.sv
// Button front end for the snake command queue: synchronize, debounce, edge-detect and
// serialize five buttons into one-cycle LE strobes. Define BTN_REPEAT_EN for hold auto-repeat.
module boton_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GAP_CYCLES      = 2,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    output logic       LE,
    output logic [2:0] boton_pres,
    output logic [4:0] btn_db
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);
`ifdef BTN_REPEAT_EN
    localparam int RW  = $clog2(REPEAT_CYCLES + 1);
`endif

    if (DEBOUNCE_CYCLES < 1 || GAP_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("boton_encoder: DEBOUNCE_CYCLES, GAP_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    logic [4:0]    s1_reg, s2_reg;
    logic [4:0]    db_bits, db_d_reg;
    logic [4:0]    rise, rep, clr;
    logic [4:0]    pending_reg, pending_next;
    state_t        state_reg, state_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [2:0]    pres_reg, pres_next;
    logic [2:0]    sel_idx;
    logic          issue_ok;
    logic          le_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            db_d_reg <= '0;
        end else begin
            s1_reg   <= btn;
            s2_reg   <= s1_reg;
            db_d_reg <= db_bits;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_bit
            logic [DBW-1:0] cnt_reg;
            logic [DBW-1:0] cnt_inc;
            logic           db_reg;

            assign cnt_inc     = cnt_reg + DBW'(1);
            assign db_bits[gi] = db_reg;

            // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (s2_reg[gi] == db_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_inc == DBW'(DEBOUNCE_CYCLES)) begin
                    cnt_reg <= '0;
                    db_reg  <= ~db_reg;
                end else begin
                    cnt_reg <= cnt_inc;
                end
            end

`ifdef BTN_REPEAT_EN
            logic [RW-1:0] hold_reg;

            assign rep[gi] = db_reg && (hold_reg == RW'(REPEAT_CYCLES));

            // Counts cycles since the press (or the last repeat) while the button stays down.
            always_ff @(posedge clk) begin
                if (rst || !db_reg) begin
                    hold_reg <= '0;
                end else if (rise[gi] || rep[gi]) begin
                    hold_reg <= RW'(1);
                end else begin
                    hold_reg <= hold_reg + RW'(1);
                end
            end
`else
            assign rep[gi] = 1'b0;
`endif
        end
    endgenerate

    assign rise = db_bits & ~db_d_reg;

    always_comb begin
        sel_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (pending_reg[k]) begin
                sel_idx = 3'(k);
            end
        end
    end

    // The last gap cycle doubles as the idle decision so the LE-low gap is exactly GAP_CYCLES.
    assign issue_ok = (state_reg == IDLE) || ((state_reg == GAP) && (gap_cnt_reg == '0));

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        pres_next    = pres_reg;
        clr          = '0;
        case (state_reg)
            STROBE: begin
                state_next   = GAP;
                gap_cnt_next = GW'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - GW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (issue_ok && (pending_reg != '0)) begin
            state_next = STROBE;
            pres_next  = sel_idx + 3'd1;
            clr        = 5'd1 << sel_idx;
        end
        pending_next = (pending_reg & ~clr) | rise | rep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            pres_reg    <= '0;
            pending_reg <= '0;
            le_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            pres_reg    <= pres_next;
            pending_reg <= pending_next;
            le_reg      <= (state_next == STROBE);
        end
    end

    assign LE         = le_reg;
    assign boton_pres = pres_reg;
    assign btn_db     = db_bits;

endmodule

// File: tb/tb_boton_encoder.sv
// Directed bench for boton_encoder with DEBOUNCE_CYCLES=4, GAP_CYCLES=2, REPEAT_CYCLES=20.
module tb_boton_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       LE;
    logic [2:0] boton_pres;
    logic [4:0] btn_db;

    int checks = 0;
    int errors = 0;

    boton_encoder #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES(2),
        .REPEAT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .LE(LE),
        .boton_pres(boton_pres),
        .btn_db(btn_db)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        logic       le;
        logic [2:0] code;
        logic [4:0] db;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        btn = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int le_cnt;
        int bad;
        int first_c;
        int prev_c;
        int t_le[2];
        int c_le[2];
        int exp_pulses;

        // Clean press of btn[2] at edge 0, released so that edge 12 samples the low level.
        for (int i = 0; i < 20; i++) begin
            vecs[i].btn  = (i < 12) ? 5'b00100 : 5'b00000;
            vecs[i].db   = (i >= 5 && i < 17) ? 5'b00100 : 5'b00000;
            vecs[i].le   = (i == 7);
            vecs[i].code = (i >= 7) ? 3'd3 : 3'd0;
        end

        reset_dut();
        check("reset_le", int'(LE), 0);
        check("reset_code", int'(boton_pres), 0);
        check("reset_db", int'(btn_db), 0);

        for (int i = 0; i < 20; i++) begin
            btn = vecs[i].btn;
            tick();
            check($sformatf("press_e%0d_le", i), int'(LE), int'(vecs[i].le));
            check($sformatf("press_e%0d_code", i), int'(boton_pres), int'(vecs[i].code));
            check($sformatf("press_e%0d_db", i), int'(btn_db), int'(vecs[i].db));
        end

        // Bounce: three-cycle high runs never reach four stable samples.
        reset_dut();
        bad = 0;
        le_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            btn = ((c % 4) != 3) ? 5'b00001 : 5'b00000;
            tick();
            if (btn_db != 5'b0) bad++;
            if (LE) le_cnt++;
        end
        btn = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (LE) le_cnt++;
        end
        check("bounce_db_changes", bad, 0);
        check("bounce_le_count", le_cnt, 0);

        // Simultaneous btn[0] and btn[3]: codes 1 then 4, two LE-low cycles between.
        reset_dut();
        btn = 5'b01001;
        le_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (LE) begin
                if (le_cnt < 2) begin
                    t_le[le_cnt] = c;
                    c_le[le_cnt] = int'(boton_pres);
                end
                le_cnt++;
            end
        end
        check("simul_le_count", le_cnt, 2);
        if (le_cnt >= 2) begin
            check("simul_first_edge", t_le[0], 7);
            check("simul_first_code", c_le[0], 1);
            check("simul_second_edge", t_le[1], 10);
            check("simul_second_code", c_le[1], 4);
        end

        // Reset lands on the edge that would raise LE, with btn[4] also pending.
        reset_dut();
        btn = 5'b10001;
        for (int c = 0; c < 7; c++) tick();
        check("rst_mid_db_before", int'(btn_db), 5'b10001);
        rst = 1'b1;
        tick();
        check("rst_mid_le", int'(LE), 0);
        check("rst_mid_code", int'(boton_pres), 0);
        check("rst_mid_db", int'(btn_db), 0);
        rst = 1'b0;
        btn = 5'b10000;
        le_cnt = 0;
        first_c = -1;
        for (int j = 1; j <= 14; j++) begin
            tick();
            if (j == 5) check("rst_redb_e5_db", int'(btn_db), 0);
            if (j == 6) check("rst_redb_e6_db", int'(btn_db), 5'b10000);
            if (LE) begin
                if (first_c < 0) begin
                    first_c = j;
                    check("rst_redb_code", int'(boton_pres), 5);
                end
                le_cnt++;
            end
        end
        check("rst_redb_le_count", le_cnt, 1);
        check("rst_redb_first_edge", first_c, 8);

        // Hold btn[1] for 100 cycles.
`ifdef BTN_REPEAT_EN
        exp_pulses = 5;
`else
        exp_pulses = 1;
`endif
        reset_dut();
        btn = 5'b00010;
        le_cnt = 0;
        first_c = -1;
        prev_c = -1;
        bad = 0;
        for (int c = 0; c < 140; c++) begin
            if (c == 100) btn = '0;
            tick();
            if (LE) begin
                le_cnt++;
                if (boton_pres != 3'd2) bad++;
                if (first_c < 0) first_c = c;
                else if (c - prev_c != 20) bad++;
                prev_c = c;
            end
        end
        check("hold_le_count", le_cnt, exp_pulses);
        check("hold_first_edge", first_c, 7);
        check("hold_code_or_spacing_errs", bad, 0);

        // Release only: btn[3] release after a completed press issues nothing.
        reset_dut();
        btn = 5'b01000;
        le_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (LE) le_cnt++;
        end
        check("rel_press_le_count", le_cnt, 1);
        check("rel_press_code", int'(boton_pres), 4);
        btn = '0;
        le_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (j == 4) check("rel_e4_db3", int'(btn_db[3]), 1);
            if (j == 5) check("rel_e5_db3", int'(btn_db[3]), 0);
            if (LE) le_cnt++;
        end
        check("rel_le_count", le_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boton_encoder.md
# boton_encoder

Front end for the snake game's direction-command queue: turns five raw, asynchronous push-buttons into the single-cycle strobe and 3-bit code that the command memory consumes. Each button is synchronized and debounced, then its press is edge-detected and held as pending. Pending presses are issued one at a time as an LE pulse carrying `boton_pres` (codes 1–5), with a mandatory LE-low gap after each pulse so the memory can pop its next instruction. Sits between the board button pins and the command memory feeding the snake state machine.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronized level must differ from the debounced level before it is accepted; must be ≥1.
- `GAP_CYCLES`, default 2: cycles LE is held low after each strobe; must be ≥1.
- `REPEAT_CYCLES`, default 12500000: auto-repeat period; used only with `BTN_REPEAT_EN`.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `btn` input 5: raw buttons, active-high, asynchronous. `btn[i]` maps to code i+1 (up=1, down=2, left=3, right=4, center=5).
- `LE` output 1: load strobe, high for exactly one cycle per issued press.
- `boton_pres` output 3: code of the press; valid while LE=1, then holds its last value.
- `btn_db` output 5: debounced button levels.

## Operation
- Synchronizer: two flip-flops per bit (`s1`, `s2`), reset to 0.
- Debounce, per bit: counter of width clog2(DEBOUNCE_CYCLES+1).
  - If `s2 == btn_db[i]`, the counter clears.
  - Otherwise it increments. When the incremented value would equal DEBOUNCE_CYCLES, `btn_db[i]` flips and the counter clears.
- Edge detect: `db_d` is `btn_db` delayed one cycle. A rising edge is `btn_db & ~db_d` and sets `pending[i]`. Falling edges are ignored.
- Pending is a 5-bit mask. A press on a button already pending merges into that pending entry (no counting). When a set and a clear of the same bit land in the same cycle, the set wins.
- FSM states: IDLE, STROBE, GAP.
  - IDLE: if pending≠0, select the lowest set index k, clear `pending[k]`, load `boton_pres`=k+1, go to STROBE. Otherwise stay in IDLE.
  - STROBE: LE=1 for this single cycle, then go to GAP and load the gap counter with GAP_CYCLES-1.
  - GAP: LE=0; count down; at 0 go to IDLE.
- LE is a registered decode of state==STROBE.
- LE is never asserted with `boton_pres`=0; code 0 is reserved for the consumer's clear function.
- Reset values: LE=0, `boton_pres`=0, `btn_db`=0, pending=0, all counters 0, state IDLE.
- Reset mid-operation (any state) returns all of the above to reset values on that edge. Pending presses are discarded, and a button still held after reset must re-debounce before it issues.

## Timing
- Let edge 0 be the first clock edge that samples the new raw level, with the raw level stable afterwards.
- `btn_db` rises at edge DEBOUNCE_CYCLES+1; `pending` sets at D+2; LE is high after edge D+3 (FSM idle, bit not pending).
- Minimum spacing between LE pulses is GAP_CYCLES+1 cycles.
- Any raw pulse or bounce shorter than DEBOUNCE_CYCLES consecutive stable cycles produces no `btn_db` change.
- Simultaneous presses are issued in ascending code order, one per strobe slot.

## Configuration
- `BTN_REPEAT_EN` defined: each button has a hold counter.
  - The counter starts at its rising edge.
  - While `btn_db[i]` stays 1, `pending[i]` is re-set every REPEAT_CYCLES cycles; the first repeat comes REPEAT_CYCLES cycles after the rising edge.
  - The counter clears on release or reset.
- `BTN_REPEAT_EN` undefined: no hold counters are built, REPEAT_CYCLES is ignored, and a held button issues exactly one strobe.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and GAP_CYCLES=2.
- Clean press: `btn[2]` driven 1 before edge 0 -> `btn_db[2]`=1 at edge 5; LE=1 for one cycle after edge 7 with `boton_pres`=3; LE=0 thereafter.
- Bounce rejection: `btn[0]` toggles 1,0 with 3-cycle high runs for 40 cycles -> `btn_db`=0 and LE never asserts.
- Simultaneous press: `btn[0]` and `btn[3]` rise together -> LE with code 1, then 2 low cycles, then LE with code 4; exactly two strobes.
- Reset mid-strobe: `rst`=1 on the edge where LE would stay high, with `btn[4]` also pending -> after that edge LE=0, `boton_pres`=0, `btn_db`=0; no strobe until `btn[4]` re-debounces (edge 8 after rst falls, button held).
- Hold, macro off: `btn[1]` held for 100 cycles -> exactly one LE, code 2. Same stimulus with `BTN_REPEAT_EN` and REPEAT_CYCLES=20 -> five LE pulses with code 2, spaced 20 cycles apart.
- Release only: `btn[3]` released after a completed press -> `btn_db[3]` falls at edge 5 after release; no LE.
